parity_scan_engine: RTL and testbench

- Sequential memory-integrity scanner: walks every address of NUM_BANKS parity-protected memory banks, fetches data word plus stored parity bit, checks them, and accumulates results.
- Successor to the fixed 2-bank, 8-word, free-running parity-match design.
  - Parametrised in width, depth, bank count and parity sense.
  - Adds start/busy/done handshake, error counting and first-fault capture.
- Sits between the test controller and the bank memories; the memories themselves are external.

---
 rtl/parity_scan_pkg.sv | 42 ++++
 rtl/parity_check_unit.sv | 18 +
 rtl/parity_scan_engine.sv | 150 +++++++++++++++
 tb/tb_parity_scan_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_scan_pkg.sv
// Shared types and helpers for the parity scan engine.
//   state_t     : scan FSM states
//   clog2       : ceiling log2 for elaboration-time sizing
//   bank_w      : bank-select width, never narrower than 1 bit
//   parity_calc : XOR reduction of a data word with odd/even sense select
// Optional feature macro used elsewhere: PARITY_SCAN_STOP_ON_ERR_EN.
package parity_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Widest data word parity_calc accepts; callers zero-extend, which
    // leaves the XOR reduction unchanged.
    localparam int MAX_DATA_W = 1024;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // A single bank still gets a 1-bit select so the port never vanishes.
    function automatic int bank_w(input int num_banks);
        return (clog2(num_banks) < 1) ? 1 : clog2(num_banks);
    endfunction

    function automatic logic parity_calc(input logic [MAX_DATA_W-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_check_unit.sv
// Combinational parity checker.
//   data     : data word read from a bank
//   par      : stored parity bit for that word
//   mismatch : 1 when the stored bit disagrees with the recomputed parity
module parity_check_unit
    import parity_scan_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic [DATA_W-1:0] data,
    input  logic              par,
    output logic              mismatch
);

    assign mismatch = (parity_calc(MAX_DATA_W'(data), PARITY_ODD) != par);

endmodule

// File: rtl/parity_scan_engine.sv
// Sequential memory-integrity scanner over NUM_BANKS parity-protected banks.
// Each word takes two cycles: READ issues the strobe, CHECK evaluates the
// returned data/parity one cycle later.
// Ports:
//   clk, reset_n          : clock (rising edge), asynchronous active-low reset
//   start                 : one-cycle scan request, honoured only in IDLE
//   stop_on_err           : (only with PARITY_SCAN_STOP_ON_ERR_EN) end the
//                           scan at the first mismatch when high
//   mem_rd_en/bank/addr   : read request to the external banks
//   mem_rdata, mem_par    : read data and stored parity, 1 cycle after strobe
//   busy, done            : scan in progress / one-cycle end-of-scan pulse
//   match                 : result of the most recent check
//   err_count             : saturating mismatch count for the current scan
//   first_err_valid/_idx  : {bank,addr} of the first mismatch of the scan
// Macro: PARITY_SCAN_STOP_ON_ERR_EN adds stop_on_err and early termination.
module parity_scan_engine
    import parity_scan_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int NUM_BANKS  = 2,
    parameter int CNT_W      = 8,
    parameter bit PARITY_ODD = 1'b0,
    localparam int BANK_W    = bank_w(NUM_BANKS),
    localparam int IDX_W     = BANK_W + ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
`ifdef PARITY_SCAN_STOP_ON_ERR_EN
    input  logic              stop_on_err,
`endif
    output logic              mem_rd_en,
    output logic [BANK_W-1:0] mem_bank,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_par,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_err_valid,
    output logic [IDX_W-1:0]  first_err_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANKS * (2 ** ADDR_W) - 1);

    state_t             state_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               rd_en_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               match_reg;
    logic [CNT_W-1:0]   err_count_reg;
    logic               first_valid_reg;
    logic [IDX_W-1:0]   first_idx_reg;

    logic mismatch;
    logic stop_now;
    logic last_word;

    parity_check_unit #(
        .DATA_W     (DATA_W),
        .PARITY_ODD (PARITY_ODD)
    ) u_check (
        .data     (mem_rdata),
        .par      (mem_par),
        .mismatch (mismatch)
    );

`ifdef PARITY_SCAN_STOP_ON_ERR_EN
    assign stop_now = stop_on_err & mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // The scan ends on this compare, so idx never wraps within a scan.
    assign last_word = (idx_reg == LAST_IDX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= S_IDLE;
            idx_reg         <= '0;
            rd_en_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            match_reg       <= 1'b1;
            err_count_reg   <= '0;
            first_valid_reg <= 1'b0;
            first_idx_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg       <= S_READ;
                        idx_reg         <= '0;
                        err_count_reg   <= '0;
                        first_valid_reg <= 1'b0;
                        first_idx_reg   <= '0;
                        busy_reg        <= 1'b1;
                        rd_en_reg       <= 1'b1;
                    end
                end
                S_READ: begin
                    state_reg <= S_CHECK;
                    rd_en_reg <= 1'b0;
                end
                S_CHECK: begin
                    match_reg <= ~mismatch;
                    if (mismatch) begin
                        if (err_count_reg != {CNT_W{1'b1}}) begin
                            err_count_reg <= err_count_reg + CNT_W'(1);
                        end
                        if (!first_valid_reg) begin
                            first_valid_reg <= 1'b1;
                            first_idx_reg   <= idx_reg;
                        end
                    end
                    if (last_word || stop_now) begin
                        state_reg <= S_DONE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                    end else begin
                        idx_reg   <= idx_reg + IDX_W'(1);
                        state_reg <= S_READ;
                        rd_en_reg <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_rd_en       = rd_en_reg;
    assign mem_bank        = idx_reg[IDX_W-1 -: BANK_W];
    assign mem_addr        = idx_reg[ADDR_W-1:0];
    assign busy            = busy_reg;
    assign done            = done_reg;
    assign match           = match_reg;
    assign err_count       = err_count_reg;
    assign first_err_valid = first_valid_reg;
    assign first_err_idx   = first_idx_reg;

endmodule

// File: tb/tb_parity_scan_engine.sv
// Self-checking bench for parity_scan_engine: table of scan scenarios with
// a read-address scoreboard and a result scoreboard, plus hand-written
// sequences for re-start, mid-scan reset, counter saturation and (with
// PARITY_SCAN_STOP_ON_ERR_EN) early stop.
module tb_parity_scan_engine;

    typedef struct packed {
        logic [15:0] bad;        // words whose stored parity is flipped
        logic [7:0]  exp_cnt;
        logic        exp_fv;
        logic [3:0]  exp_fi;
        logic        exp_match;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       start;
    logic       start_s;
`ifdef PARITY_SCAN_STOP_ON_ERR_EN
    logic       stop_on_err;
`endif

    logic       mem_rd_en;
    logic [0:0] mem_bank;
    logic [2:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_par;
    logic       busy;
    logic       done;
    logic       match;
    logic [7:0] err_count;
    logic       first_err_valid;
    logic [3:0] first_err_idx;

    logic       mem_rd_en_s;
    logic [0:0] mem_bank_s;
    logic [2:0] mem_addr_s;
    logic [7:0] mem_rdata_s;
    logic       mem_par_s;
    logic       busy_s;
    logic       done_s;
    logic       match_s;
    logic [2:0] err_count_s;
    logic       first_err_valid_s;
    logic [3:0] first_err_idx_s;

    logic [7:0] mem_data [16];
    logic       mem_pbit [16];

    parity_scan_engine dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
`ifdef PARITY_SCAN_STOP_ON_ERR_EN
        .stop_on_err     (stop_on_err),
`endif
        .mem_rd_en       (mem_rd_en),
        .mem_bank        (mem_bank),
        .mem_addr        (mem_addr),
        .mem_rdata       (mem_rdata),
        .mem_par         (mem_par),
        .busy            (busy),
        .done            (done),
        .match           (match),
        .err_count       (err_count),
        .first_err_valid (first_err_valid),
        .first_err_idx   (first_err_idx)
    );

    parity_scan_engine #(.CNT_W(3)) dut_s (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start_s),
`ifdef PARITY_SCAN_STOP_ON_ERR_EN
        .stop_on_err     (1'b0),
`endif
        .mem_rd_en       (mem_rd_en_s),
        .mem_bank        (mem_bank_s),
        .mem_addr        (mem_addr_s),
        .mem_rdata       (mem_rdata_s),
        .mem_par         (mem_par_s),
        .busy            (busy_s),
        .done            (done_s),
        .match           (match_s),
        .err_count       (err_count_s),
        .first_err_valid (first_err_valid_s),
        .first_err_idx   (first_err_idx_s)
    );

    // Bank memory model: one-cycle registered read for each instance.
    always_ff @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rdata <= mem_data[{mem_bank, mem_addr}];
            mem_par   <= mem_pbit[{mem_bank, mem_addr}];
        end
        if (mem_rd_en_s) begin
            mem_rdata_s <= mem_data[{mem_bank_s, mem_addr_s}];
            mem_par_s   <= mem_pbit[{mem_bank_s, mem_addr_s}];
        end
    end

    int tests_run    = 0;
    int tests_failed = 0;

    logic [3:0] addr_q [$];
    vec_t       res_q  [$];
    vec_t       vecs   [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [15:0] bad);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            d = (i == 5) ? 8'b10010111 : 8'(i * 37 + 11);
            mem_data[i] = d;
            mem_pbit[i] = (^d) ^ bad[i];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // IDLE cycle that follows DONE.
    task automatic do_scan(input vec_t v, input int n_words, input bit repulse);
        int   cyc;
        bit   got_done;
        vec_t r;
        load_mem(v.bad);
        for (int i = 0; i < n_words; i++) addr_q.push_back(4'(i));
        res_q.push_back(v);
        start    = 1'b1;
        cyc      = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            start = (repulse && cyc == 10);
            if (cyc == 1) begin
                check("busy_after_start", 32'(busy), 32'd1);
                check("err_cleared", 32'(err_count), 32'd0);
                check("fv_cleared", 32'(first_err_valid), 32'd0);
            end
            if (mem_rd_en) begin
                if (addr_q.size() == 0) check("unexpected_strobe", 32'(mem_rd_en), 32'd0);
                else check("rd_addr", 32'({mem_bank, mem_addr}), 32'(addr_q.pop_front()));
            end
            if (done) begin
                got_done = 1'b1;
                r = res_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(2 * n_words + 1));
                check("busy_in_done", 32'(busy), 32'd0);
                check("err_count", 32'(err_count), 32'(r.exp_cnt));
                check("first_err_valid", 32'(first_err_valid), 32'(r.exp_fv));
                check("first_err_idx", 32'(first_err_idx), 32'(r.exp_fi));
                check("match", 32'(match), 32'(r.exp_match));
                $display("[TB] scan bad=%h words=%0d done@%0d cnt=%0d fv=%0b fi=%0d match=%0b",
                         v.bad, n_words, cyc, err_count, first_err_valid, first_err_idx, match);
            end
        end
        if (!got_done) check("done_timeout", 32'(done), 32'd1);
        check("strobes_left", 32'(addr_q.size()), 32'd0);
        // A start offered during DONE must be ignored.
        if (repulse) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (repulse) begin
            for (int k = 0; k < 3; k++) begin
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_done", 32'(done), 32'd0);
                check("idle_rd_en", 32'(mem_rd_en), 32'd0);
                check("hold_err_count", 32'(err_count), 32'(v.exp_cnt));
                @(negedge clk);
            end
        end
    endtask

    initial begin
        int   cyc;
        bit   got;
        vec_t sv;

        vecs[0] = '{bad: 16'h0000, exp_cnt: 8'd0,  exp_fv: 1'b0, exp_fi: 4'd0,  exp_match: 1'b1};
        vecs[1] = '{bad: 16'h0420, exp_cnt: 8'd2,  exp_fv: 1'b1, exp_fi: 4'd5,  exp_match: 1'b1};
        vecs[2] = '{bad: 16'h8000, exp_cnt: 8'd1,  exp_fv: 1'b1, exp_fi: 4'd15, exp_match: 1'b0};
        vecs[3] = '{bad: 16'h0007, exp_cnt: 8'd3,  exp_fv: 1'b1, exp_fi: 4'd0,  exp_match: 1'b1};
        vecs[4] = '{bad: 16'hFFFF, exp_cnt: 8'd16, exp_fv: 1'b1, exp_fi: 4'd0,  exp_match: 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
`ifdef PARITY_SCAN_STOP_ON_ERR_EN
        stop_on_err = 1'b0;
`endif
        load_mem(16'h0000);
        repeat (2) @(negedge clk);
        check("rst_rd_en", 32'(mem_rd_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_match", 32'(match), 32'd1);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_fv", 32'(first_err_valid), 32'd0);
        check("rst_fi", 32'(first_err_idx), 32'd0);
        check("rst_idx", 32'({mem_bank, mem_addr}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) do_scan(vecs[i], 16, (i == 1));

        // Mid-scan reset: five errors recorded, then reset_n drops at cycle 12.
        load_mem(16'h001F);
        for (int i = 0; i < 16; i++) addr_q.push_back(4'(i));
        start = 1'b1;
        for (cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_rd_en) check("rst_seq_rd_addr", 32'({mem_bank, mem_addr}), 32'(addr_q.pop_front()));
        end
        check("pre_rst_err_count", 32'(err_count), 32'd5);
        check("pre_rst_match", 32'(match), 32'd0);
        reset_n = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_err_count", 32'(err_count), 32'd0);
        check("async_rst_match", 32'(match), 32'd1);
        check("async_rst_fv", 32'(first_err_valid), 32'd0);
        check("async_rst_rd_en", 32'(mem_rd_en), 32'd0);
        addr_q.delete();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        $display("[TB] mid-scan reset sequence complete");
        do_scan(vecs[0], 16, 1'b0);

        // Saturation on the CNT_W=3 instance.
        load_mem(16'hFFFF);
        start_s = 1'b1;
        got     = 1'b0;
        for (cyc = 1; cyc <= 100 && !got; cyc++) begin
            @(negedge clk);
            start_s = 1'b0;
            if (done_s) begin
                got = 1'b1;
                check("sat_err_count", 32'(err_count_s), 32'd7);
                check("sat_fi", 32'(first_err_idx_s), 32'd0);
                check("sat_fv", 32'(first_err_valid_s), 32'd1);
                check("sat_done_cycle", 32'(cyc), 32'd33);
                $display("[TB] saturation scan cnt=%0d fi=%0d", err_count_s, first_err_idx_s);
            end
        end
        if (!got) check("sat_done_timeout", 32'(done_s), 32'd1);
        @(negedge clk);

`ifdef PARITY_SCAN_STOP_ON_ERR_EN
        stop_on_err = 1'b1;
        sv = '{bad: 16'h0088, exp_cnt: 8'd1, exp_fv: 1'b1, exp_fi: 4'd3, exp_match: 1'b0};
        do_scan(sv, 4, 1'b0);
        stop_on_err = 1'b0;
`else
        sv = vecs[1];
        do_scan(sv, 16, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
